// File: rtl/eerrl_pkg.sv
// Shared EER-RL node definitions: packet types, engine state encoding, default widths.
package eerrl_pkg;

    localparam int unsigned WORD_WIDTH_DEF = 16;
    localparam int unsigned PKT_W_DEF      = 3;
    localparam int unsigned STATE_W        = 3;

    localparam logic [2:0] PKT_HELLO  = 3'b001;
    localparam logic [2:0] PKT_CH_ANN = 3'b010;
    localparam logic [2:0] PKT_DATA   = 3'b101;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SCAN     = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_CH_SCAN  = 3'd3;
    localparam logic [2:0] S_CH_WRITE = 3'd4;
    localparam logic [2:0] S_BEST     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

endpackage

// File: rtl/nbr_qtable_engine_if.sv
// Packet/command, status and debug-readout bundle of the neighbour/Q-table engine.
interface nbr_qtable_engine_if
    import eerrl_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int unsigned NBR_DEPTH  = 16,
    parameter int unsigned CH_DEPTH   = 8,
    parameter int unsigned PKT_W      = PKT_W_DEF
);
    localparam int unsigned IW  = $clog2(NBR_DEPTH);
    localparam int unsigned CW  = $clog2(NBR_DEPTH + 1);
    localparam int unsigned CCW = $clog2(CH_DEPTH + 1);

    logic                  en;
    logic                  clr;
    logic [WORD_WIDTH-1:0] f_source_id;
    logic [WORD_WIDTH-1:0] f_cluster_id;
    logic [WORD_WIDTH-1:0] f_energy;
    logic [WORD_WIDTH-1:0] f_qvalue;
    logic [PKT_W-1:0]      f_pkt_type;
    logic                  busy;
    logic                  done;
    logic                  hit;
    logic                  dropped;
    logic [CW-1:0]         nbr_count;
    logic [CCW-1:0]        ch_count;
    logic                  best_valid;
    logic [WORD_WIDTH-1:0] best_id;
    logic [WORD_WIDTH-1:0] best_q;
    logic [IW-1:0]         rd_index;
    logic [WORD_WIDTH-1:0] rd_id;
    logic [WORD_WIDTH-1:0] rd_cluster;
    logic [WORD_WIDTH-1:0] rd_energy;
    logic [WORD_WIDTH-1:0] rd_qvalue;

    modport master (
        output en, clr, f_source_id, f_cluster_id, f_energy, f_qvalue, f_pkt_type, rd_index,
        input  busy, done, hit, dropped, nbr_count, ch_count, best_valid, best_id, best_q,
               rd_id, rd_cluster, rd_energy, rd_qvalue
    );

    modport slave (
        input  en, clr, f_source_id, f_cluster_id, f_energy, f_qvalue, f_pkt_type, rd_index,
        output busy, done, hit, dropped, nbr_count, ch_count, best_valid, best_id, best_q,
               rd_id, rd_cluster, rd_energy, rd_qvalue
    );

endinterface

// File: rtl/nbr_entry_regfile.sv
// Neighbour entry storage: id/cluster/energy/Q per slot, one write port,
// combinational scan (id, Q) and debug (all fields) read ports.
module nbr_entry_regfile
    import eerrl_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IW-1:0]         wr_idx_i,
    input  logic [WORD_WIDTH-1:0] wr_id_i,
    input  logic [WORD_WIDTH-1:0] wr_cluster_i,
    input  logic [WORD_WIDTH-1:0] wr_energy_i,
    input  logic [WORD_WIDTH-1:0] wr_qvalue_i,
    input  logic [IW-1:0]         scan_idx_i,
    output logic [WORD_WIDTH-1:0] scan_id_o,
    output logic [WORD_WIDTH-1:0] scan_qvalue_o,
    input  logic [IW-1:0]         rd_idx_i,
    output logic [WORD_WIDTH-1:0] rd_id_o,
    output logic [WORD_WIDTH-1:0] rd_cluster_o,
    output logic [WORD_WIDTH-1:0] rd_energy_o,
    output logic [WORD_WIDTH-1:0] rd_qvalue_o
);
    logic [WORD_WIDTH-1:0] id_q      [DEPTH];
    logic [WORD_WIDTH-1:0] cluster_q [DEPTH];
    logic [WORD_WIDTH-1:0] energy_q  [DEPTH];
    logic [WORD_WIDTH-1:0] qvalue_q  [DEPTH];

    // Contents are left unreset; validity is tracked by the owner's entry count.
    always_ff @(posedge clk) begin
        if (we_i) begin
            id_q[wr_idx_i]      <= wr_id_i;
            cluster_q[wr_idx_i] <= wr_cluster_i;
            energy_q[wr_idx_i]  <= wr_energy_i;
            qvalue_q[wr_idx_i]  <= wr_qvalue_i;
        end
    end

    assign scan_id_o     = id_q[scan_idx_i];
    assign scan_qvalue_o = qvalue_q[scan_idx_i];
    assign rd_id_o       = id_q[rd_idx_i];
    assign rd_cluster_o  = cluster_q[rd_idx_i];
    assign rd_energy_o   = energy_q[rd_idx_i];
    assign rd_qvalue_o   = qvalue_q[rd_idx_i];

endmodule

// File: rtl/nbr_qtable_engine.sv
// Neighbour/Q-table update engine: per packet, match-or-append the sender, track
// known cluster heads, then rescan the table to publish the best-Q next hop.
module nbr_qtable_engine
    import eerrl_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int unsigned NBR_DEPTH  = 16,
    parameter int unsigned CH_DEPTH   = 8,
    parameter int unsigned PKT_W      = PKT_W_DEF
) (
    input logic                clk,
    input logic                nrst,
    nbr_qtable_engine_if.slave bus
);
    localparam int unsigned IW  = $clog2(NBR_DEPTH);
    localparam int unsigned CW  = $clog2(NBR_DEPTH + 1);
    localparam int unsigned CIW = $clog2(CH_DEPTH);
    localparam int unsigned CCW = $clog2(CH_DEPTH + 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         wr_idx_q, wr_idx_d;
    logic [CIW-1:0]        ch_idx_q, ch_idx_d;
    logic [WORD_WIDTH-1:0] src_q, src_d;
    logic [WORD_WIDTH-1:0] cl_q, cl_d;
    logic [WORD_WIDTH-1:0] eng_q, eng_d;
    logic [WORD_WIDTH-1:0] qv_q, qv_d;
    logic [PKT_W-1:0]      typ_q, typ_d;
    logic                  hit_q, hit_d;
    logic                  dropped_q, dropped_d;
    logic [CW-1:0]         nbr_count_q, nbr_count_d;
    logic [CCW-1:0]        ch_count_q, ch_count_d;
    logic [WORD_WIDTH-1:0] cand_id_q, cand_id_d;
    logic [WORD_WIDTH-1:0] cand_q_q, cand_q_d;
    logic                  best_valid_q, best_valid_d;
    logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
    logic [WORD_WIDTH-1:0] best_q_q, best_q_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic [WORD_WIDTH-1:0] ch_list_q [CH_DEPTH];

    logic                  wr_en_c;
    logic                  ch_we_c;
    logic                  ch_fin_c;
    logic                  table_type_c;
    logic                  is_ch_c;
    logic                  rd_valid_c;
    logic [WORD_WIDTH-1:0] scan_id_c;
    logic [WORD_WIDTH-1:0] scan_q_c;
    logic [WORD_WIDTH-1:0] rf_id_c;
    logic [WORD_WIDTH-1:0] rf_cluster_c;
    logic [WORD_WIDTH-1:0] rf_energy_c;
    logic [WORD_WIDTH-1:0] rf_qvalue_c;

    nbr_entry_regfile #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (NBR_DEPTH),
        .IW         (IW)
    ) u_regfile (
        .clk           (clk),
        .we_i          (wr_en_c),
        .wr_idx_i      (wr_idx_q),
        .wr_id_i       (src_q),
        .wr_cluster_i  (cl_q),
        .wr_energy_i   (eng_q),
        .wr_qvalue_i   (qv_q),
        .scan_idx_i    (idx_q),
        .scan_id_o     (scan_id_c),
        .scan_qvalue_o (scan_q_c),
        .rd_idx_i      (bus.rd_index),
        .rd_id_o       (rf_id_c),
        .rd_cluster_o  (rf_cluster_c),
        .rd_energy_o   (rf_energy_c),
        .rd_qvalue_o   (rf_qvalue_c)
    );

    assign table_type_c = (bus.f_pkt_type == PKT_W'(PKT_HELLO))
                       || (bus.f_pkt_type == PKT_W'(PKT_CH_ANN))
                       || (bus.f_pkt_type == PKT_W'(PKT_DATA));
    assign is_ch_c      = (typ_q == PKT_W'(PKT_CH_ANN));

    // Next-state and datapath control.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wr_idx_d     = wr_idx_q;
        ch_idx_d     = ch_idx_q;
        src_d        = src_q;
        cl_d         = cl_q;
        eng_d        = eng_q;
        qv_d         = qv_q;
        typ_d        = typ_q;
        hit_d        = hit_q;
        dropped_d    = dropped_q;
        nbr_count_d  = nbr_count_q;
        ch_count_d   = ch_count_q;
        cand_id_d    = cand_id_q;
        cand_q_d     = cand_q_q;
        best_valid_d = best_valid_q;
        best_id_d    = best_id_q;
        best_q_d     = best_q_q;
        done_d       = 1'b0;
        wr_en_c      = 1'b0;
        ch_we_c      = 1'b0;
        ch_fin_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    src_d     = bus.f_source_id;
                    cl_d      = bus.f_cluster_id;
                    eng_d     = bus.f_energy;
                    qv_d      = bus.f_qvalue;
                    typ_d     = bus.f_pkt_type;
                    hit_d     = 1'b0;
                    dropped_d = 1'b0;
                    idx_d     = '0;
                    state_d   = table_type_c ? S_SCAN : S_DONE;
                end else if (bus.clr) begin
                    nbr_count_d  = '0;
                    ch_count_d   = '0;
                    best_valid_d = 1'b0;
                end
            end
            S_SCAN: begin
                if ((nbr_count_q != '0) && (scan_id_c == src_q)) begin
                    hit_d    = 1'b1;
                    wr_idx_d = idx_q;
                    state_d  = S_WRITE;
                end else if ((nbr_count_q == '0) || (CW'(idx_q) + CW'(1) == nbr_count_q)) begin
                    if (nbr_count_q < CW'(NBR_DEPTH)) begin
                        wr_idx_d = IW'(nbr_count_q);
                        state_d  = S_WRITE;
                    end else begin
                        // Table full: the sender is dropped and the best hop stays as published.
                        dropped_d = 1'b1;
                        ch_idx_d  = '0;
                        state_d   = is_ch_c ? S_CH_SCAN : S_DONE;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_WRITE: begin
                wr_en_c = 1'b1;
                if (!hit_q) begin
                    nbr_count_d = nbr_count_q + CW'(1);
                end
                idx_d    = '0;
                ch_idx_d = '0;
                state_d  = is_ch_c ? S_CH_SCAN : S_BEST;
            end
            S_CH_SCAN: begin
                if ((ch_count_q != '0) && (ch_list_q[ch_idx_q] == src_q)) begin
                    ch_fin_c = 1'b1;
                end else if ((ch_count_q == '0) || (CCW'(ch_idx_q) + CCW'(1) == ch_count_q)) begin
                    if (ch_count_q < CCW'(CH_DEPTH)) begin
                        state_d = S_CH_WRITE;
                    end else begin
                        ch_fin_c = 1'b1;
                    end
                end else begin
                    ch_idx_d = ch_idx_q + CIW'(1);
                end
            end
            S_CH_WRITE: begin
                ch_we_c    = 1'b1;
                ch_count_d = ch_count_q + CCW'(1);
                ch_fin_c   = 1'b1;
            end
            S_BEST: begin
                // Strict greater-than keeps the lowest index on equal Q.
                if ((idx_q == '0) || (scan_q_c > cand_q_q)) begin
                    cand_id_d = scan_id_c;
                    cand_q_d  = scan_q_c;
                end
                if (CW'(idx_q) + CW'(1) == nbr_count_q) begin
                    best_valid_d = 1'b1;
                    best_id_d    = cand_id_d;
                    best_q_d     = cand_q_d;
                    state_d      = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ch_fin_c) begin
            idx_d   = '0;
            state_d = dropped_q ? S_DONE : S_BEST;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            wr_idx_q     <= '0;
            ch_idx_q     <= '0;
            src_q        <= '0;
            cl_q         <= '0;
            eng_q        <= '0;
            qv_q         <= '0;
            typ_q        <= '0;
            hit_q        <= 1'b0;
            dropped_q    <= 1'b0;
            nbr_count_q  <= '0;
            ch_count_q   <= '0;
            cand_id_q    <= '0;
            cand_q_q     <= '0;
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            best_q_q     <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_idx_q     <= wr_idx_d;
            ch_idx_q     <= ch_idx_d;
            src_q        <= src_d;
            cl_q         <= cl_d;
            eng_q        <= eng_d;
            qv_q         <= qv_d;
            typ_q        <= typ_d;
            hit_q        <= hit_d;
            dropped_q    <= dropped_d;
            nbr_count_q  <= nbr_count_d;
            ch_count_q   <= ch_count_d;
            cand_id_q    <= cand_id_d;
            cand_q_q     <= cand_q_d;
            best_valid_q <= best_valid_d;
            best_id_q    <= best_id_d;
            best_q_q     <= best_q_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    // Known-CH list storage, masked by ch_count.
    always_ff @(posedge clk) begin
        if (ch_we_c) begin
            ch_list_q[CIW'(ch_count_q)] <= src_q;
        end
    end

    assign rd_valid_c = (CW'(bus.rd_index) < nbr_count_q);

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.hit        = hit_q;
    assign bus.dropped    = dropped_q;
    assign bus.nbr_count  = nbr_count_q;
    assign bus.ch_count   = ch_count_q;
    assign bus.best_valid = best_valid_q;
    assign bus.best_id    = best_id_q;
    assign bus.best_q     = best_q_q;
    assign bus.rd_id      = rd_valid_c ? rf_id_c      : '0;
    assign bus.rd_cluster = rd_valid_c ? rf_cluster_c : '0;
    assign bus.rd_energy  = rd_valid_c ? rf_energy_c  : '0;
    assign bus.rd_qvalue  = rd_valid_c ? rf_qvalue_c  : '0;

endmodule

// File: tb/tb_nbr_qtable_engine.sv
// Directed bench for nbr_qtable_engine with a 4-entry table and 2-entry CH list.
module tb_nbr_qtable_engine;
    import eerrl_pkg::*;

    localparam int unsigned W   = 16;
    localparam int unsigned ND  = 4;
    localparam int unsigned CD  = 2;
    localparam int unsigned PW  = 3;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;
    int   lat;
    int   ndone;

    nbr_qtable_engine_if #(.WORD_WIDTH(W), .NBR_DEPTH(ND), .CH_DEPTH(CD), .PKT_W(PW)) bus ();

    nbr_qtable_engine #(.WORD_WIDTH(W), .NBR_DEPTH(ND), .CH_DEPTH(CD), .PKT_W(PW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one packet and wait (bounded) for done; lat = edges from the en sample to done.
    task automatic send(input logic [2:0] typ, input logic [15:0] id, input logic [15:0] cl,
                        input logic [15:0] e, input logic [15:0] q, input bit poke,
                        output int lat_o);
        int cyc;
        bit seen;
        @(negedge clk);
        bus.f_pkt_type   = typ;
        bus.f_source_id  = id;
        bus.f_cluster_id = cl;
        bus.f_energy     = e;
        bus.f_qvalue     = q;
        bus.en           = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.done) begin
                seen = 1'b1;
            end else if (cyc == 1) begin
                bus.clr = 1'b0;
                if (poke) bus.f_source_id = 16'd50;
                else      bus.en = 1'b0;
            end else if (cyc == 2) begin
                bus.en = 1'b0;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        lat_o = cyc - 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nrst = 1'b0;
        bus.en = 1'b0;
        bus.clr = 1'b0;
        bus.f_pkt_type = '0;
        bus.f_source_id = '0;
        bus.f_cluster_id = '0;
        bus.f_energy = '0;
        bus.f_qvalue = '0;
        bus.rd_index = '0;
        #23;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_nbr", 32'(bus.nbr_count), 32'd0);
        chk("rst_ch", 32'(bus.ch_count), 32'd0);
        chk("rst_bv", 32'(bus.best_valid), 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        // First neighbour into an empty table.
        send(PKT_DATA, 16'd1, 16'd2, 16'h8000, 16'h3000, 1'b0, lat);
        chk("p1_lat", 32'(lat), 32'd4);
        chk("p1_nbr", 32'(bus.nbr_count), 32'd1);
        chk("p1_hit", 32'(bus.hit), 32'd0);
        chk("p1_busy", 32'(bus.busy), 32'd0);
        chk("p1_bid", 32'(bus.best_id), 32'd1);
        chk("p1_bq", 32'(bus.best_q), 32'h3000);
        chk("p1_rd_en", 32'(bus.rd_energy), 32'h8000);
        bus.rd_index = 2'd1;
        #1;
        chk("p1_rd_masked", 32'(bus.rd_id), 32'd0);
        bus.rd_index = 2'd0;
        @(posedge clk);
        #1;
        chk("p1_done_pulse", 32'(bus.done), 32'd0);

        // Update of the same source.
        send(PKT_DATA, 16'd1, 16'd3, 16'h1800, 16'hB800, 1'b0, lat);
        chk("p2_lat", 32'(lat), 32'd4);
        chk("p2_hit", 32'(bus.hit), 32'd1);
        chk("p2_nbr", 32'(bus.nbr_count), 32'd1);
        chk("p2_rd_cl", 32'(bus.rd_cluster), 32'd3);
        chk("p2_bq", 32'(bus.best_q), 32'hB800);

        send(PKT_HELLO, 16'd2, 16'd1, 16'h0100, 16'hC000, 1'b0, lat);
        chk("p3_lat", 32'(lat), 32'd5);
        chk("p3_bid", 32'(bus.best_id), 32'd2);
        chk("p3_bq", 32'(bus.best_q), 32'hC000);

        // Lowering the current best must hand the hop back to id 1.
        send(PKT_DATA, 16'd2, 16'd1, 16'h0100, 16'h1000, 1'b0, lat);
        chk("p4_lat", 32'(lat), 32'd6);
        chk("p4_hit", 32'(bus.hit), 32'd1);
        chk("p4_bid", 32'(bus.best_id), 32'd1);
        chk("p4_bq", 32'(bus.best_q), 32'hB800);

        send(PKT_CH_ANN, 16'd5, 16'd5, 16'h0200, 16'h0500, 1'b0, lat);
        chk("p5_lat", 32'(lat), 32'd9);
        chk("p5_nbr", 32'(bus.nbr_count), 32'd3);
        chk("p5_ch", 32'(bus.ch_count), 32'd1);

        send(PKT_CH_ANN, 16'd5, 16'd5, 16'h0200, 16'h0500, 1'b0, lat);
        chk("p6_lat", 32'(lat), 32'd9);
        chk("p6_hit", 32'(bus.hit), 32'd1);
        chk("p6_ch_dup", 32'(bus.ch_count), 32'd1);

        // Equal Q at a higher index must not displace index 0.
        send(PKT_HELLO, 16'd7, 16'd2, 16'h0300, 16'hB800, 1'b0, lat);
        chk("p7_lat", 32'(lat), 32'd9);
        chk("p7_nbr", 32'(bus.nbr_count), 32'd4);
        chk("p7_tie_bid", 32'(bus.best_id), 32'd1);

        send(PKT_DATA, 16'd99, 16'd9, 16'h0400, 16'hFFFF, 1'b0, lat);
        chk("p8_lat", 32'(lat), 32'd5);
        chk("p8_drop", 32'(bus.dropped), 32'd1);
        chk("p8_nbr", 32'(bus.nbr_count), 32'd4);
        chk("p8_bid", 32'(bus.best_id), 32'd1);
        chk("p8_bq", 32'(bus.best_q), 32'hB800);

        send(PKT_CH_ANN, 16'd98, 16'd9, 16'h0400, 16'hFFFF, 1'b0, lat);
        chk("p9_lat", 32'(lat), 32'd7);
        chk("p9_drop", 32'(bus.dropped), 32'd1);
        chk("p9_ch", 32'(bus.ch_count), 32'd2);
        chk("p9_bq", 32'(bus.best_q), 32'hB800);

        // CH list full: id 1 is new to it but must not be stored.
        send(PKT_CH_ANN, 16'd1, 16'd3, 16'h1800, 16'h0200, 1'b0, lat);
        chk("p10_lat", 32'(lat), 32'd9);
        chk("p10_ch_full", 32'(bus.ch_count), 32'd2);
        chk("p10_drop", 32'(bus.dropped), 32'd0);
        chk("p10_bid", 32'(bus.best_id), 32'd7);

        send(3'b111, 16'd33, 16'd0, 16'd0, 16'd0, 1'b0, lat);
        chk("p11_lat", 32'(lat), 32'd1);
        chk("p11_hit", 32'(bus.hit), 32'd0);
        chk("p11_nbr", 32'(bus.nbr_count), 32'd4);

        // en held through the busy window with a new id must be ignored.
        send(PKT_DATA, 16'd2, 16'd1, 16'h0100, 16'h2000, 1'b1, lat);
        chk("p12_lat", 32'(lat), 32'd8);
        chk("p12_hit", 32'(bus.hit), 32'd1);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("p12_no_second_done", 32'(ndone), 32'd0);
        chk("p12_nbr", 32'(bus.nbr_count), 32'd4);

        // Asynchronous reset in the middle of a scan.
        @(negedge clk);
        bus.f_pkt_type  = PKT_DATA;
        bus.f_source_id = 16'd60;
        bus.en          = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        chk("r_busy_before", 32'(bus.busy), 32'd1);
        nrst = 1'b0;
        #1;
        chk("r_busy", 32'(bus.busy), 32'd0);
        chk("r_nbr", 32'(bus.nbr_count), 32'd0);
        chk("r_ch", 32'(bus.ch_count), 32'd0);
        chk("r_bv", 32'(bus.best_valid), 32'd0);
        chk("r_bid", 32'(bus.best_id), 32'd0);
        chk("r_rd_id", 32'(bus.rd_id), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) ndone++;
        end
        chk("r_idle_after", 32'(ndone), 32'd0);

        send(PKT_DATA, 16'd3, 16'd1, 16'h0100, 16'h4444, 1'b0, lat);
        chk("c1_lat", 32'(lat), 32'd4);
        chk("c1_bid", 32'(bus.best_id), 32'd3);
        send(PKT_CH_ANN, 16'd4, 16'd4, 16'h0100, 16'h1111, 1'b0, lat);
        chk("c2_lat", 32'(lat), 32'd7);
        chk("c2_nbr", 32'(bus.nbr_count), 32'd2);
        chk("c2_ch", 32'(bus.ch_count), 32'd1);
        chk("c2_bid", 32'(bus.best_id), 32'd3);

        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        chk("clr_nbr", 32'(bus.nbr_count), 32'd0);
        chk("clr_ch", 32'(bus.ch_count), 32'd0);
        chk("clr_bv", 32'(bus.best_valid), 32'd0);

        // en and clr together: the packet is processed, nothing is cleared.
        bus.clr = 1'b1;
        send(PKT_DATA, 16'd8, 16'd1, 16'h0100, 16'h0001, 1'b0, lat);
        chk("c3_lat", 32'(lat), 32'd4);
        chk("c3_nbr", 32'(bus.nbr_count), 32'd1);
        chk("c3_bv", 32'(bus.best_valid), 32'd1);
        chk("c3_bid", 32'(bus.best_id), 32'd8);
        chk("c3_bq", 32'(bus.best_q), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nbr_qtable_engine.md
# nbr_qtable_engine

Parametrised neighbour/Q-table update engine for the EER-RL node datapath. On a start pulse it takes one decoded packet and does three things:
- scans an internal neighbour table and updates a matching entry, or appends a new one;
- for cluster-head announcements, maintains a deduplicated known-CH list;
- rescans the table to publish the current best-Q next hop.

It replaces the fixed-depth, external-memory-bank update block with self-contained, depth-parametrised storage and adds best-hop tracking, overflow reporting and a table clear.

## Interface
Parameters:
- WORD_WIDTH, 16, width of IDs, energy, Q-values
- NBR_DEPTH, 16, neighbour table entries (≥2)
- CH_DEPTH, 8, known-CH list entries (≥2)
- PKT_W, 3, packet-type width

Ports:
- clk  in  1  clock
- nrst  in  1  reset; one clock, reset asynchronous active-low
- en  in  1  start pulse, sampled only in IDLE
- clr  in  1  clear tables, sampled only in IDLE; en wins if both high
- f_source_id, f_cluster_id, f_energy, f_qvalue  in  WORD_WIDTH each  packet fields
- f_pkt_type  in  PKT_W  packet type
- busy  out  1  high from the cycle after en is sampled until done
- done  out  1  one-cycle pulse at end of operation
- hit  out  1  source matched an existing entry (valid from done until next en)
- dropped  out  1  new neighbour not stored, table full (valid from done until next en)
- nbr_count  out  $clog2(NBR_DEPTH+1)  valid neighbour entries
- ch_count  out  $clog2(CH_DEPTH+1)  valid CH entries
- best_valid, best_id, best_q  out  1/WORD_WIDTH/WORD_WIDTH  highest-Q neighbour
- rd_index  in  $clog2(NBR_DEPTH)  debug/readout index
- rd_id, rd_cluster, rd_energy, rd_qvalue  out  WORD_WIDTH  combinational read of entry rd_index; zero if rd_index ≥ nbr_count

## Operation
- Packet types:
  - HELLO=3'b001 updates the neighbour table.
  - CH_ANN=3'b010 updates the neighbour table and the CH list.
  - DATA=3'b101 updates the neighbour table.
  - Any other type: no table change; done follows after SCAN is skipped (IDLE→DONE).
- FSM states: IDLE, SCAN, WRITE, CH_SCAN, CH_WRITE, BEST, DONE.
- IDLE:
  - en=1 latches all f_* fields, clears hit/dropped, sets idx=0, goes to SCAN.
  - Otherwise, clr=1 zeroes nbr_count, ch_count and best_valid in one cycle.
- SCAN: one entry per cycle.
  - Entry idx ID equals the latched source → hit=1, go to WRITE at idx.
  - Last valid entry passed, or nbr_count=0 → miss. If nbr_count<NBR_DEPTH, go to WRITE at nbr_count. If full, set dropped=1 and skip WRITE and BEST.
- WRITE:
  - Hit: overwrite cluster/energy/Q of the entry.
  - Miss: write all four fields at nbr_count, then nbr_count+1.
- CH_SCAN / CH_WRITE (CH_ANN only, after WRITE or drop):
  - Scan the CH list one per cycle for f_source_id.
  - If absent and ch_count<CH_DEPTH, append it in CH_WRITE.
  - Duplicate or full: no write, no flag.
- BEST: one entry per cycle over 0..nbr_count-1, unsigned compare of Q-values; strict greater-than, so ties keep the lowest index. Publish best_id/best_q/best_valid at the end of the scan. Skipped when dropped.
- DONE: pulse done for one cycle, return to IDLE. en during any non-IDLE state is ignored (not queued).
- Reset: all counts, flags, done, busy, best_* and FSM go to 0/IDLE immediately, including mid-operation. Table contents need not be cleared (masked by counts).

## Timing
- Edge 0 samples en. Then:
  - SCAN: k+1 cycles for a hit at index k; max(nbr_count,1) cycles for a miss.
  - WRITE: 1 cycle.
  - CH_SCAN: max(ch_count,1) cycles, CH_ANN only.
  - CH_WRITE: 1 cycle if appended.
  - BEST: nbr_count cycles (post-write).
  - DONE: 1 cycle.
- Outputs registered. nbr_count updates the edge after WRITE. best_* updates the edge after the last BEST cycle.

## Structure
- Shared package eerrl_pkg: packet-type constants (HELLO, CH_ANN, DATA), the FSM state enum, default WORD_WIDTH.
- Sub-module nbr_entry_regfile: NBR_DEPTH×4-field register array, one write port, two combinational read ports (scan and debug). Used for the neighbour table.
- The CH list is a single-field array inline.

## Test plan
- Empty table, DATA id=1 cl=2 E=16'h8000 Q=16'h3000 → done 4 edges after en; nbr_count=1, hit=0, best_id=1, best_q=16'h3000.
- Then DATA id=1 cl=3 E=16'h1800 Q=16'hB800 → hit=1, nbr_count=1, entry 0 cluster=3, best_q=16'hB800.
- Add id=2 Q=16'hC000, then update id=2 to Q=16'h1000 → best_id returns to 1 (Q=16'hB800), proving the rescan on a lowered best.
- Fill NBR_DEPTH entries, then send new id=99 → dropped=1, nbr_count=NBR_DEPTH, best unchanged. Repeat with CH_ANN: the CH list is still updated.
- CH_ANN id=5 twice → ch_count=1. Fill the CH list, then CH_ANN for a new id → ch_count stays CH_DEPTH.
- Reset asserted mid-SCAN, and en pulsed while busy → immediate zero outputs/IDLE; no second done; clr in IDLE zeroes counts and best_valid.
